if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- instruction fetch stage
//
// Fetches one 32-bit instruction word per request from a handshake-style
// instruction memory and presents it, with its PC+4, to the IF/ID register.
// Decode can stall the stage (Hazard). A taken branch redirects the fetch and
// flushes whatever was in flight.
//
// Three FSM states:
//   FETCH  a request to imem_addr is outstanding
//   HOLD   an instruction arrived during a stall and is parked in the buffer;
//          no request is issued until the stall lifts
//   DRAIN  a branch redirected the PC while a request was still outstanding;
//          the stale response is awaited and thrown away
//
// Ports
//   clk            single clock, rising edge
//   rst            asynchronous active-low reset
//   Hazard         stall request from decode: hold PC and outputs
//   BranchTaken    redirect fetch to BranchTarget, flush in-flight fetch
//   BranchTarget   redirect address, bits [1:0] forced to zero
//   imem_req       instruction-memory request
//   imem_addr      word-aligned fetch address, stable until imem_ack
//   imem_ack       imem_rdata is valid this cycle
//   imem_rdata     fetched instruction word
//   PCOut          PC+4 of the instruction on InstructionOut
//   InstructionOut fetched instruction or NOP
//   ValidOut       InstructionOut carries a real fetched instruction
// -----------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Hazard,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCOut,
  output logic [31:0] InstructionOut,
  output logic        ValidOut
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Clear the two byte-offset bits so every fetch address is word aligned.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  // Registered state
  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] drain_addr_r;   // address of the request being drained
  logic [31:0] buf_pc_r;
  logic [31:0] buf_instr_r;
  logic        buf_valid_r;
  logic [31:0] out_pc_r;
  logic [31:0] out_instr_r;
  logic        out_valid_r;

  // Next-state values
  state_t      state_s;
  logic [31:0] pc_s;
  logic [31:0] drain_addr_s;
  logic [31:0] buf_pc_s;
  logic [31:0] buf_instr_s;
  logic        buf_valid_s;
  logic [31:0] out_pc_s;
  logic [31:0] out_instr_s;
  logic        out_valid_s;

  logic [31:0] pc_plus4_s;
  logic [31:0] target_s;

  assign pc_plus4_s = pc_r + 32'd4;   // wraps modulo 2^32
  assign target_s   = align_word(BranchTarget);

  // While draining, the memory still owns the old request, so its address is
  // replayed until the ack even though pc_r already holds the branch target.
  assign imem_addr = (state_r == DRAIN) ? drain_addr_r : pc_r;
  // HOLD issues no request; reset forces the request low immediately.
  assign imem_req  = rst & (state_r != HOLD);

  assign PCOut          = out_pc_r;
  assign InstructionOut = out_instr_r;
  assign ValidOut       = out_valid_r;

  // Next-state and next-output logic: branch beats stall beats normal fetch.
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    drain_addr_s = drain_addr_r;
    buf_pc_s     = buf_pc_r;
    buf_instr_s  = buf_instr_r;
    buf_valid_s  = buf_valid_r;
    out_pc_s     = out_pc_r;
    out_instr_s  = out_instr_r;
    out_valid_s  = out_valid_r;

    if (BranchTaken) begin
      // Redirect: emit a bubble, drop any buffered instruction, ignore Hazard.
      pc_s        = target_s;
      out_pc_s    = pc_r;
      out_instr_s = NOP;
      out_valid_s = 1'b0;
      buf_valid_s = 1'b0;
      case (state_r)
        FETCH: begin
          if (imem_ack) begin
            // Response lands with the branch: discard it, fetch target next.
            state_s = FETCH;
          end else begin
            // Request still open: remember its address and wait it out.
            state_s      = DRAIN;
            drain_addr_s = pc_r;
          end
        end
        DRAIN: begin
          // Latest target wins; the original stale request is still pending.
          if (imem_ack) begin
            state_s = FETCH;
          end else begin
            state_s = DRAIN;
          end
        end
        HOLD: begin
          state_s = FETCH;
        end
        default: begin
          state_s = FETCH;
        end
      endcase
    end else begin
      case (state_r)
        FETCH: begin
          if (Hazard) begin
            if (imem_ack) begin
              // Data arrives during a stall: park it, outputs keep their value.
              buf_pc_s    = pc_plus4_s;
              buf_instr_s = imem_rdata;
              buf_valid_s = 1'b1;
              pc_s        = pc_plus4_s;
              state_s     = HOLD;
            end else begin
              state_s = FETCH;
            end
          end else begin
            if (imem_ack) begin
              out_pc_s    = pc_plus4_s;
              out_instr_s = imem_rdata;
              out_valid_s = 1'b1;
              pc_s        = pc_plus4_s;
            end else begin
              out_pc_s    = pc_r;
              out_instr_s = NOP;
              out_valid_s = 1'b0;
            end
            state_s = FETCH;
          end
        end
        HOLD: begin
          if (Hazard) begin
            state_s = HOLD;
          end else begin
            out_pc_s    = buf_pc_r;
            out_instr_s = buf_instr_r;
            out_valid_s = buf_valid_r;
            buf_valid_s = 1'b0;
            state_s     = FETCH;
          end
        end
        DRAIN: begin
          if (Hazard) begin
            out_valid_s = out_valid_r;
          end else begin
            out_pc_s    = pc_r;
            out_instr_s = NOP;
            out_valid_s = 1'b0;
          end
          // The stale response is dropped whatever the stall says.
          if (imem_ack) begin
            state_s = FETCH;
          end else begin
            state_s = DRAIN;
          end
        end
        default: begin
          state_s = FETCH;
        end
      endcase
    end
  end

  // State, PC, buffer and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= FETCH;
      pc_r         <= RESET_PC;
      drain_addr_r <= RESET_PC;
      buf_pc_r     <= 32'h0000_0000;
      buf_instr_r  <= NOP;
      buf_valid_r  <= 1'b0;
      out_pc_r     <= 32'h0000_0000;
      out_instr_r  <= NOP;
      out_valid_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      drain_addr_r <= drain_addr_s;
      buf_pc_r     <= buf_pc_s;
      buf_instr_r  <= buf_instr_s;
      buf_valid_r  <= buf_valid_s;
      out_pc_r     <= out_pc_s;
      out_instr_r  <= out_instr_s;
      out_valid_r  <= out_valid_s;
    end
  end

endmodule
